debug_dump_sequencer: RTL and testbench

//  Parametrised debug snapshot engine. Halts the MIPS pipeline and streams one frame of state to the UART TX path:

---
 rtl/debug_pkg.sv | 7 +
 rtl/dbg_latch_walker.sv | 24 ++
 rtl/debug_dump_sequencer.sv | 110 +++++++++++
 tb/tb_debug_dump_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// debug_pkg: shared states, frame sections and constants for the debug dump sequencer
package debug_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_SEND, S_DONE, S_HOLD, S_STEP} state_t;
  typedef enum logic [2:0] {SEC_HDR, SEC_PC, SEC_REG, SEC_MEM, SEC_LAT} sec_t;
  localparam logic [15:0] HDR_TAG = 16'hDB60;
  localparam int N_STG = 5;
endpackage

// File: rtl/dbg_latch_walker.sv
// dbg_latch_walker: stage/signal counter that walks the pipeline-latch mux select
module dbg_latch_walker
  import debug_pkg::*;
#(
  parameter logic [4*N_STG-1:0] STG_CNT = {4'd2, 4'd5, 4'd11, 4'd7, 4'd2}
)(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       adv,
  output logic [6:0] sel,
  output logic       last
);
  logic [2:0] stg;
  logic [3:0] sig;
  logic       stg_end;
  assign stg_end = sig == STG_CNT[{stg, 2'b00} +: 4] - 4'd1;
  assign last = stg == 3'(N_STG - 1) && stg_end;
  assign sel = {stg, sig};
  always_ff @(posedge clk or posedge rst)
    if (rst) {stg, sig} <= '0;
    else if (clr) {stg, sig} <= '0;
    else if (adv && !last) {stg, sig} <= stg_end ? {stg + 3'd1, 4'd0} : {stg, sig + 4'd1};
endmodule

// File: rtl/debug_dump_sequencer.sv
// debug_dump_sequencer: halts the core and streams one snapshot frame of its state to the UART
module debug_dump_sequencer
  import debug_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG = 32,
  parameter int MEM_WORDS = 20,
  parameter int MEM_BASE = 0,
  parameter int MEM_AW = 10,
  parameter logic [4*N_STG-1:0] STG_CNT = {4'd2, 4'd5, 4'd11, 4'd7, 4'd2},
  parameter int READ_LAT = 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_cmd,
  input  logic              step_mode,
  input  logic              trig_en,
  input  logic [DATA_W-1:0] trig_pc,
  input  logic [DATA_W-1:0] pc,
  output logic [4:0]        reg_addr,
  input  logic [DATA_W-1:0] reg_data,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [6:0]        latch_sel,
  input  logic [DATA_W-1:0] latch_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              halt_cpu,
  output logic              debug_on,
  output logic              dump_done,
  output logic [15:0]       frame_cnt
);
  localparam int IW = $clog2((NREG > MEM_WORDS ? NREG : MEM_WORDS) + 1);
  state_t            state, state_n;
  sec_t              sec;
  logic [IW-1:0]     idx;
  logic [1:0]        wcnt;
  logic [DATA_W-1:0] pc_lat, src;
  logic [6:0]        walk_sel;
  logic              armed, step_r, bp_hit, trig, start, hs, lat_last, sec_end;
  assign bp_hit = trig_en && pc == trig_pc && armed;
  assign trig = start_cmd || bp_hit;
  assign start = (state == S_IDLE && trig) || state == S_STEP;
  assign hs = state == S_SEND && tx_ready;
  assign sec_end = sec == SEC_HDR || sec == SEC_PC ||
                   (sec == SEC_REG && idx == IW'(NREG - 1)) ||
                   (sec == SEC_MEM && idx == IW'(MEM_WORDS - 1));
  assign src = sec == SEC_HDR ? DATA_W'({HDR_TAG, frame_cnt}) :
               sec == SEC_PC  ? pc_lat :
               sec == SEC_REG ? reg_data :
               sec == SEC_MEM ? mem_data : latch_data;
  assign reg_addr = sec == SEC_REG ? 5'(idx) : '0;
  assign mem_addr = sec == SEC_MEM ? MEM_AW'(MEM_BASE) + MEM_AW'(idx) : '0;
  assign latch_sel = sec == SEC_LAT ? walk_sel : '0;
  dbg_latch_walker #(.STG_CNT(STG_CNT)) u_walker (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .adv  (hs && sec == SEC_LAT),
    .sel  (walk_sel),
    .last (lat_last)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: state_n = trig ? S_ADDR : S_IDLE;
      S_ADDR: state_n = READ_LAT == 0 ? S_SEND : S_WAIT;
      S_WAIT: state_n = wcnt == 2'(READ_LAT - 1) ? S_SEND : S_WAIT;
      S_SEND: state_n = !tx_ready ? S_SEND : (sec == SEC_LAT && lat_last) ? S_DONE : S_ADDR;
      S_DONE: state_n = step_r ? S_HOLD : S_IDLE;
      S_HOLD: state_n = !step_mode ? S_IDLE : start_cmd ? S_STEP : S_HOLD;
      S_STEP: state_n = S_ADDR;
      default: state_n = S_IDLE;
    endcase
    halt_cpu = !(state inside {S_IDLE, S_STEP});
    debug_on = state inside {S_ADDR, S_WAIT, S_SEND, S_DONE};
    tx_valid = state == S_SEND;
    dump_done = state == S_DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sec <= SEC_HDR;
      idx <= '0;
      wcnt <= '0;
      pc_lat <= '0;
      tx_data <= '0;
      armed <= 1'b1;
      step_r <= 1'b0;
      frame_cnt <= '0;
    end else begin
      armed <= (state == S_IDLE && bp_hit) ? 1'b0 : (pc != trig_pc) ? 1'b1 : armed;
      wcnt <= state == S_WAIT ? wcnt + 2'd1 : 2'd0;
      if (start) begin
        sec <= SEC_HDR;
        idx <= '0;
        pc_lat <= pc;
      end
      if (state == S_IDLE && trig) step_r <= step_mode;
      if (state_n == S_SEND && state != S_SEND) tx_data <= src;
      if (hs && sec != SEC_LAT) begin
        sec <= sec_end ? sec_t'(sec + 3'd1) : sec;
        idx <= sec_end ? '0 : idx + 1'b1;
      end
      if (state == S_DONE) frame_cnt <= frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb_debug_dump_sequencer: scoreboard bench for frame content, handshake, triggers, stepping and reset
`timescale 1ns/1ps
module tb_debug_dump_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start_cmd = 1'b0, start2 = 1'b0, step_mode = 1'b0, trig_en = 1'b0, tx_ready = 1'b1;
  logic [31:0] trig_pc = '0, pc = '0;
  logic [4:0] ra1, ra2;
  logic [9:0] ma1, ma2;
  logic [6:0] ls1, ls2;
  logic [31:0] rd1, md1, ld1, txd1, rd2, md2, ld2, txd2;
  logic txv1, halt1, don1, dd1, txv2, halt2, don2, dd2;
  logic [15:0] fc1, fc2;
  logic [4:0] ra1_q;
  logic [9:0] ma1_q;
  logic [6:0] ls1_q;
  logic [2:0][4:0] ra2_q;
  logic [2:0][9:0] ma2_q;
  logic [2:0][6:0] ls2_q;
  function automatic logic [31:0] rf(input logic [4:0] a);
    return 32'h1000_0000 + 32'(a) * 32'd3;
  endfunction
  function automatic logic [31:0] mf(input logic [9:0] a);
    return 32'hA000_0000 + 32'(a) * 32'h11;
  endfunction
  function automatic logic [31:0] lf(input logic [6:0] s);
    return 32'h5000_0000 + 32'(s) * 32'h101;
  endfunction
  always @(posedge clk) begin
    ra1_q <= ra1; ma1_q <= ma1; ls1_q <= ls1;
    ra2_q <= {ra2_q[1:0], ra2}; ma2_q <= {ma2_q[1:0], ma2}; ls2_q <= {ls2_q[1:0], ls2};
  end
  assign rd1 = rf(ra1_q);
  assign md1 = mf(ma1_q);
  assign ld1 = lf(ls1_q);
  assign rd2 = rf(ra2_q[2]);
  assign md2 = mf(ma2_q[2]);
  assign ld2 = lf(ls2_q[2]);
  debug_dump_sequencer u_dut (
    .clk(clk), .rst(rst), .start_cmd(start_cmd), .step_mode(step_mode), .trig_en(trig_en),
    .trig_pc(trig_pc), .pc(pc), .reg_addr(ra1), .reg_data(rd1), .mem_addr(ma1), .mem_data(md1),
    .latch_sel(ls1), .latch_data(ld1), .tx_data(txd1), .tx_valid(txv1), .tx_ready(tx_ready),
    .halt_cpu(halt1), .debug_on(don1), .dump_done(dd1), .frame_cnt(fc1)
  );
  debug_dump_sequencer #(.MEM_WORDS(4), .MEM_BASE(8), .READ_LAT(3)) u_dut_lat (
    .clk(clk), .rst(rst), .start_cmd(start2), .step_mode(1'b0), .trig_en(1'b0),
    .trig_pc(32'h0), .pc(32'hC0DE_0008), .reg_addr(ra2), .reg_data(rd2), .mem_addr(ma2), .mem_data(md2),
    .latch_sel(ls2), .latch_data(ld2), .tx_data(txd2), .tx_valid(txv2), .tx_ready(tx_ready),
    .halt_cpu(halt2), .debug_on(don2), .dump_done(dd2), .frame_cnt(fc2)
  );
  int n_pass = 0, n_chk = 0;
  int cnt[5] = '{2, 7, 11, 5, 2};
  logic [31:0] exp_q[$], got_q[$];
  logic [9:0] gma_q[$];
  logic [15:0] fc_m = '0;
  bit to;
  int stab_err;
  logic [6:0] done_sel;
  logic done_halt;
  task automatic push_frame(input logic [31:0] pcv, input logic [15:0] fc, input int mb, input int mw);
    exp_q.push_back({16'hDB60, fc});
    exp_q.push_back(pcv);
    for (int r = 0; r < 32; r++) exp_q.push_back(rf(5'(r)));
    for (int m = 0; m < mw; m++) exp_q.push_back(mf(10'(mb + m)));
    for (int s = 0; s < 5; s++)
      for (int g = 0; g < cnt[s]; g++) exp_q.push_back(lf({3'(s), 4'(g)}));
  endtask
  task automatic collect(input bit d2, input bit rnd, input int stop_n);
    logic pv, v, dn;
    logic [31:0] pd, d;
    pv = 1'b0; pd = '0; to = 1'b1; stab_err = 0;
    got_q.delete(); gma_q.delete();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      v = d2 ? txv2 : txv1;
      d = d2 ? txd2 : txd1;
      dn = d2 ? dd2 : dd1;
      if (pv && (!v || d !== pd)) stab_err++;
      if (dn) begin
        to = 1'b0;
        done_sel = d2 ? ls2 : ls1;
        done_halt = d2 ? halt2 : halt1;
        break;
      end
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v && tx_ready) begin
        got_q.push_back(d);
        gma_q.push_back(d2 ? ma2 : ma1);
      end
      pv = v && !tx_ready;
      pd = d;
      if (got_q.size() >= stop_n) begin
        to = 1'b0;
        break;
      end
    end
    tx_ready = 1'b1;
  endtask
  task automatic pulse_start();
    @(negedge clk); start_cmd = 1'b1;
    @(negedge clk); start_cmd = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({txv1, txd1, halt1, don1, dd1, fc1, ra1, ma1, ls1} !== '0)
      $display("FAIL reset_outputs: got %h, want 0", {txv1, txd1, halt1, don1, dd1, fc1, ra1, ma1, ls1});
    else n_pass++;
    n_chk++;
    if ({txv2, txd2, halt2, don2, dd2, fc2, ra2, ma2, ls2} !== '0)
      $display("FAIL reset_outputs_lat: got %h, want 0", {txv2, txd2, halt2, don2, dd2, fc2, ra2, ma2, ls2});
    else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({halt1, don1, txv1} !== 3'b000) $display("FAIL reset_idle: got %b, want 000", {halt1, don1, txv1});
    else n_pass++;
  endtask
  task automatic test_run();
    logic [31:0] w;
    pc = 32'h0040_0100;
    push_frame(pc, fc_m, 0, 20);
    pulse_start();
    n_chk++;
    if ({halt1, don1} !== 2'b11) $display("FAIL run_halt_rise: got %b, want 11", {halt1, don1});
    else n_pass++;
    collect(1'b0, 1'b0, 1000);
    n_chk++; if (to !== 1'b0) $display("FAIL run_timeout: got no dump_done, want dump_done"); else n_pass++;
    n_chk++; if (got_q.size() != 81) $display("FAIL run_count: got %0d, want 81", got_q.size()); else n_pass++;
    foreach (got_q[i]) begin
      w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      n_chk++;
      if (got_q[i] !== w) $display("FAIL run_word%0d: got %h, want %h", i, got_q[i], w); else n_pass++;
    end
    exp_q.delete();
    n_chk++; if (done_sel !== 7'h41) $display("FAIL run_last_sel: got %h, want 41", done_sel); else n_pass++;
    n_chk++; if (done_halt !== 1'b1) $display("FAIL run_halt_done: got %b, want 1", done_halt); else n_pass++;
    @(negedge clk);
    n_chk++;
    if ({dd1, halt1, don1} !== 3'b000) $display("FAIL run_after_done: got %b, want 000", {dd1, halt1, don1});
    else n_pass++;
    fc_m++;
    n_chk++; if (fc1 !== fc_m) $display("FAIL run_frame_cnt: got %0d, want %0d", fc1, fc_m); else n_pass++;
  endtask
  task automatic test_breakpoint();
    logic [31:0] w;
    int early, extra_done, extra_halt;
    early = 0; extra_done = 0; extra_halt = 0;
    pc = '0; trig_pc = 32'd16; trig_en = 1'b1;
    push_frame(32'd16, fc_m, 0, 20);
    repeat (16) begin
      @(negedge clk);
      if (halt1) early++;
      pc = pc + 32'd1;
    end
    n_chk++; if (early != 0) $display("FAIL bp_early_halt: got %0d cycles, want 0", early); else n_pass++;
    @(negedge clk);
    n_chk++; if (halt1 !== 1'b1) $display("FAIL bp_halt_after_hit: got %b, want 1", halt1); else n_pass++;
    collect(1'b0, 1'b0, 1000);
    n_chk++; if (to !== 1'b0) $display("FAIL bp_timeout: got no dump_done, want dump_done"); else n_pass++;
    n_chk++; if (got_q.size() != 81) $display("FAIL bp_count: got %0d, want 81", got_q.size()); else n_pass++;
    foreach (got_q[i]) begin
      w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      n_chk++;
      if (got_q[i] !== w) $display("FAIL bp_word%0d: got %h, want %h", i, got_q[i], w); else n_pass++;
    end
    exp_q.delete();
    fc_m++;
    repeat (100) begin
      @(negedge clk);
      if (dd1) extra_done++;
      if (halt1) extra_halt++;
    end
    n_chk++; if (extra_done != 0) $display("FAIL bp_single_frame: got %0d extra frames, want 0", extra_done); else n_pass++;
    n_chk++; if (extra_halt != 0) $display("FAIL bp_halt_released: got %0d halted cycles, want 0", extra_halt); else n_pass++;
    trig_en = 1'b0;
  endtask
  task automatic test_random_ready();
    logic [31:0] w;
    pc = 32'h1234_5678;
    push_frame(pc, fc_m, 0, 20);
    pulse_start();
    collect(1'b0, 1'b1, 1000);
    n_chk++; if (to !== 1'b0) $display("FAIL rnd_timeout: got no dump_done, want dump_done"); else n_pass++;
    n_chk++; if (stab_err != 0) $display("FAIL rnd_stable: got %0d changes under backpressure, want 0", stab_err); else n_pass++;
    n_chk++; if (got_q.size() != 81) $display("FAIL rnd_count: got %0d, want 81", got_q.size()); else n_pass++;
    foreach (got_q[i]) begin
      w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      n_chk++;
      if (got_q[i] !== w) $display("FAIL rnd_word%0d: got %h, want %h", i, got_q[i], w); else n_pass++;
    end
    exp_q.delete();
    fc_m++;
  endtask
  task automatic test_step();
    logic [31:0] w;
    step_mode = 1'b1; pc = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) pulse_start();
      else begin
        @(negedge clk);
        n_chk++; if (halt1 !== 1'b1) $display("FAIL step_hold_halt%0d: got %b, want 1", k, halt1); else n_pass++;
        n_chk++; if (fc1 !== fc_m) $display("FAIL step_frame_cnt%0d: got %0d, want %0d", k, fc1, fc_m); else n_pass++;
        start_cmd = 1'b1;
        @(negedge clk); start_cmd = 1'b0;
        n_chk++; if (halt1 !== 1'b0) $display("FAIL step_low%0d: got %b, want 0", k, halt1); else n_pass++;
        @(negedge clk);
        n_chk++; if (halt1 !== 1'b1) $display("FAIL step_high%0d: got %b, want 1", k, halt1); else n_pass++;
      end
      push_frame(pc, fc_m, 0, 20);
      collect(1'b0, 1'b0, 1000);
      n_chk++; if (to !== 1'b0) $display("FAIL step_timeout%0d: got no dump_done, want dump_done", k); else n_pass++;
      n_chk++; if (got_q.size() != 81) $display("FAIL step_count%0d: got %0d, want 81", k, got_q.size()); else n_pass++;
      foreach (got_q[i]) begin
        w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
        n_chk++;
        if (got_q[i] !== w) $display("FAIL step%0d_word%0d: got %h, want %h", k, i, got_q[i], w); else n_pass++;
      end
      exp_q.delete();
      fc_m++;
    end
    @(negedge clk);
    n_chk++; if (halt1 !== 1'b1) $display("FAIL step_final_hold: got %b, want 1", halt1); else n_pass++;
    step_mode = 1'b0;
    @(negedge clk);
    n_chk++; if (halt1 !== 1'b0) $display("FAIL step_exit: got %b, want 0", halt1); else n_pass++;
    n_chk++; if (fc1 !== fc_m) $display("FAIL step_exit_cnt: got %0d, want %0d", fc1, fc_m); else n_pass++;
  endtask
  task automatic test_reset_mid();
    logic [31:0] w;
    bit seen;
    pc = 32'h0000_0300;
    push_frame(pc, fc_m, 0, 20);
    pulse_start();
    collect(1'b0, 1'b0, 40);
    n_chk++; if (got_q.size() != 40) $display("FAIL rstmid_count: got %0d, want 40", got_q.size()); else n_pass++;
    foreach (got_q[i]) begin
      w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      n_chk++;
      if (got_q[i] !== w) $display("FAIL rstmid_word%0d: got %h, want %h", i, got_q[i], w); else n_pass++;
    end
    exp_q.delete();
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = txv1;
    end
    n_chk++; if (!seen) $display("FAIL rstmid_word41_valid: got 0, want 1"); else n_pass++;
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if ({txv1, halt1} !== 2'b00) $display("FAIL rstmid_async: got %b, want 00", {txv1, halt1}); else n_pass++;
    n_chk++; if (fc1 !== 16'd0) $display("FAIL rstmid_frame_cnt: got %0d, want 0", fc1); else n_pass++;
    @(negedge clk); rst = 1'b0;
    fc_m = '0;
    push_frame(pc, fc_m, 0, 20);
    pulse_start();
    collect(1'b0, 1'b0, 1000);
    n_chk++; if (to !== 1'b0) $display("FAIL rstmid_timeout: got no dump_done, want dump_done"); else n_pass++;
    n_chk++; if (got_q.size() != 81) $display("FAIL rstmid_full_count: got %0d, want 81", got_q.size()); else n_pass++;
    foreach (got_q[i]) begin
      w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      n_chk++;
      if (got_q[i] !== w) $display("FAIL rstmid_full_word%0d: got %h, want %h", i, got_q[i], w); else n_pass++;
    end
    exp_q.delete();
    fc_m++;
  endtask
  task automatic test_latency();
    logic [31:0] w;
    push_frame(32'hC0DE_0008, 16'd0, 8, 4);
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    collect(1'b1, 1'b1, 1000);
    n_chk++; if (to !== 1'b0) $display("FAIL lat_timeout: got no dump_done, want dump_done"); else n_pass++;
    n_chk++; if (stab_err != 0) $display("FAIL lat_stable: got %0d changes under backpressure, want 0", stab_err); else n_pass++;
    n_chk++; if (got_q.size() != 65) $display("FAIL lat_count: got %0d, want 65", got_q.size()); else n_pass++;
    foreach (got_q[i]) begin
      w = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
      n_chk++;
      if (got_q[i] !== w) $display("FAIL lat_word%0d: got %h, want %h", i, got_q[i], w); else n_pass++;
    end
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (gma_q.size() <= 34 + i || gma_q[34 + i] !== 10'(8 + i))
        $display("FAIL lat_mem_addr%0d: got %0d, want %0d", i, gma_q.size() > 34 + i ? gma_q[34 + i] : 10'h3FF, 8 + i);
      else n_pass++;
    end
    n_chk++; if (done_sel !== 7'h41) $display("FAIL lat_last_sel: got %h, want 41", done_sel); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_run();
    test_breakpoint();
    test_random_ready();
    test_step();
    test_reset_mid();
    test_latency();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
